// File: rtl/mel_fbank_pp_if.sv
// Streaming handshake bundle for the Mel filterbank: spectrum bins in, Mel values out.
// The master drives bins and accepts Mel values; the slave is the filterbank engine.
interface mel_fbank_pp_if #(
  parameter int WIDTH     = 16,
  parameter int MEL_BANDS = 40,
  parameter int N_CH      = 4
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BAND_W = $clog2(MEL_BANDS);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic [CH_W-1:0]   in_ch;
  logic              mode_log;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [BAND_W-1:0] out_band;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, in_ch, mode_log, out_ready,
    input  in_ready, out_valid, out_data, out_band, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_ch, mode_log, out_ready,
    output in_ready, out_valid, out_data, out_band, out_ch, out_last
  );
endinterface

// File: rtl/mel_fbank_pp.sv
// Streaming Mel filterbank: loadable triangular-weight table, 3-stage MAC pipeline,
// two ping-pong accumulator banks so one frame fills while the previous one drains.
module mel_fbank_pp #(
  parameter int WIDTH     = 16,
  parameter int N_FFT     = 512,
  parameter int N_BINS    = N_FFT / 2 + 1,
  parameter int MEL_BANDS = 40,
  parameter int COEF_W    = 12,
  parameter int N_CH      = 4,
  parameter int OUT_SHIFT = 12,
  parameter int LOG_INT_W = 6,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int BIN_W    = $clog2(N_BINS),
  localparam int BAND_W   = $clog2(MEL_BANDS),
  localparam int AW       = WIDTH + COEF_W + $clog2(N_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [BIN_W-1:0]  cfg_addr,
  input  logic [BAND_W-1:0] cfg_band,
  input  logic [COEF_W-1:0] cfg_wlo,
  input  logic [COEF_W-1:0] cfg_whi,
  mel_fbank_pp_if.slave     bus,
  output logic              frame_err,
  output logic              busy
);
  localparam int PW = WIDTH + COEF_W;
  localparam int EW = BAND_W + 2 * COEF_W;
  localparam int FW = WIDTH - LOG_INT_W;

  typedef enum logic [1:0] {
    B_FREE  = 2'd0,
    B_FILL  = 2'd1,
    B_FULL  = 2'd2,
    B_DRAIN = 2'd3
  } bank_st_t;

  logic [EW-1:0]     tbl_r [N_BINS];
  logic [AW-1:0]     acc_r [2][MEL_BANDS];
  bank_st_t          bank_st_r [2];
  bank_st_t          bank_nxt_s [2];
  logic [CH_W-1:0]   bank_ch_r [2];
  logic              bank_log_r [2];

  logic [BIN_W-1:0]  bin_cnt_r;
  logic              fill_sel_r, fill_sel_nxt_s;
  logic              in_frame_r, in_frame_nxt_s;
  logic              drain_sel_r;
  logic              in_ready_r, busy_r, frame_err_r;

  logic              s1_v_r, s1_bank_r, s1_close_r;
  logic [WIDTH-1:0]  s1_data_r;
  logic [EW-1:0]     s1_ent_r;
  logic              s2_v_r, s2_bank_r, s2_close_r;
  logic [PW-1:0]     s2_plo_r, s2_phi_r;
  logic [BAND_W-1:0] s2_band_r;

  logic              out_valid_r, out_last_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [BAND_W-1:0] out_band_r;
  logic [CH_W-1:0]   out_ch_r;

  logic              accept_s, bin_last_s, close_s;
  logic              drain_start_s, drain_fire_s, drain_end_s;
  logic [BAND_W-1:0] rd_band_s;
  logic [WIDTH-1:0]  rd_val_s;

  // Accumulator to output word: linear (shift + saturate) or log2 with left-aligned mantissa.
  function automatic logic [WIDTH-1:0] fmt_out(input logic [AW-1:0] v, input logic lg);
    logic [AW-1:0]    t;
    logic [WIDTH-1:0] r;
    int               p;
    p = 0;
    if (lg) begin
      for (int i = 0; i < AW; i++) p = v[i] ? i : p;
      t = v << (AW - 1 - p);
      if (v == '0) r = '0;
      else r = {LOG_INT_W'(p), FW'(t >> (AW - 1 - FW))};
    end else begin
      t = v >> OUT_SHIFT;
      if (t > AW'({WIDTH{1'b1}})) r = '1;
      else r = WIDTH'(t);
    end
    return r;
  endfunction

  assign accept_s      = bus.in_valid && in_ready_r;
  assign bin_last_s    = (bin_cnt_r == BIN_W'(N_BINS - 1));
  assign close_s       = bus.in_last || bin_last_s;
  assign drain_fire_s  = out_valid_r && bus.out_ready;
  assign drain_end_s   = drain_fire_s && out_last_r;
  assign drain_start_s = !out_valid_r && (bank_st_r[drain_sel_r] == B_FULL);

  // Bank state and fill-side next values; in_ready/busy are registered from these.
  always_comb begin
    bank_nxt_s[0]  = bank_st_r[0];
    bank_nxt_s[1]  = bank_st_r[1];
    fill_sel_nxt_s = fill_sel_r;
    in_frame_nxt_s = in_frame_r;
    if (accept_s) begin
      if (!in_frame_r) bank_nxt_s[fill_sel_r] = B_FILL;
      else bank_nxt_s[fill_sel_r] = bank_st_r[fill_sel_r];
      if (close_s) begin
        in_frame_nxt_s = 1'b0;
        fill_sel_nxt_s = ~fill_sel_r;
      end else begin
        in_frame_nxt_s = 1'b1;
        fill_sel_nxt_s = fill_sel_r;
      end
    end else begin
      in_frame_nxt_s = in_frame_r;
    end
    if (s2_v_r && s2_close_r) bank_nxt_s[s2_bank_r] = B_FULL;
    else bank_nxt_s[s2_bank_r] = bank_nxt_s[s2_bank_r];
    if (drain_start_s) bank_nxt_s[drain_sel_r] = B_DRAIN;
    else if (drain_end_s) bank_nxt_s[drain_sel_r] = B_FREE;
    else bank_nxt_s[drain_sel_r] = bank_nxt_s[drain_sel_r];
  end

  // Next band to present and its formatted value from the draining bank.
  always_comb begin
    if (drain_fire_s && !out_last_r) rd_band_s = out_band_r + BAND_W'(1);
    else rd_band_s = '0;
    rd_val_s = fmt_out(acc_r[drain_sel_r][rd_band_s], bank_log_r[drain_sel_r]);
  end

  // Bank FSM, fill/drain pointers, bin counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_r[0] <= B_FREE;
      bank_st_r[1] <= B_FREE;
      bank_ch_r[0] <= '0;
      bank_ch_r[1] <= '0;
      bank_log_r[0] <= 1'b0;
      bank_log_r[1] <= 1'b0;
      fill_sel_r  <= 1'b0;
      in_frame_r  <= 1'b0;
      drain_sel_r <= 1'b0;
      bin_cnt_r   <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_nxt_s[0];
      bank_st_r[1] <= bank_nxt_s[1];
      fill_sel_r   <= fill_sel_nxt_s;
      in_frame_r   <= in_frame_nxt_s;
      in_ready_r   <= in_frame_nxt_s || (bank_nxt_s[fill_sel_nxt_s] == B_FREE);
      busy_r       <= (bank_nxt_s[0] != B_FREE) || (bank_nxt_s[1] != B_FREE) ||
                      accept_s || s1_v_r;
      frame_err_r  <= accept_s && (bus.in_last != bin_last_s);
      if (drain_end_s) drain_sel_r <= ~drain_sel_r;
      if (accept_s) begin
        bin_cnt_r <= close_s ? '0 : bin_cnt_r + BIN_W'(1);
        if (!in_frame_r) begin
          bank_ch_r[fill_sel_r]  <= bus.in_ch;
          bank_log_r[fill_sel_r] <= bus.mode_log;
        end
      end
    end
  end

  // Coefficient table: cleared on reset, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BINS; i++) tbl_r[i] <= '0;
    end else if (cfg_we && !busy_r && (int'(cfg_addr) < N_BINS)) begin
      tbl_r[cfg_addr] <= {cfg_band, cfg_wlo, cfg_whi};
    end
  end

  // S1 table read and S2 weight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r <= 1'b0; s1_bank_r <= 1'b0; s1_close_r <= 1'b0;
      s1_data_r <= '0; s1_ent_r <= '0;
      s2_v_r <= 1'b0; s2_bank_r <= 1'b0; s2_close_r <= 1'b0;
      s2_plo_r <= '0; s2_phi_r <= '0; s2_band_r <= '0;
    end else begin
      s1_v_r <= accept_s;
      if (accept_s) begin
        s1_data_r  <= bus.in_data;
        s1_ent_r   <= tbl_r[bin_cnt_r];
        s1_bank_r  <= fill_sel_r;
        s1_close_r <= close_s;
      end
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_plo_r   <= PW'(s1_data_r) * PW'(s1_ent_r[2*COEF_W-1 -: COEF_W]);
        s2_phi_r   <= PW'(s1_data_r) * PW'(s1_ent_r[COEF_W-1:0]);
        s2_band_r  <= s1_ent_r[EW-1 -: BAND_W];
        s2_bank_r  <= s1_bank_r;
        s2_close_r <= s1_close_r;
      end
    end
  end

  // S3 accumulate; band b+1 beyond the last band simply has no accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int bk = 0; bk < 2; bk++)
        for (int b = 0; b < MEL_BANDS; b++) acc_r[bk][b] <= '0;
    end else begin
      for (int bk = 0; bk < 2; bk++) begin
        for (int b = 0; b < MEL_BANDS; b++) begin
          if (drain_end_s && (drain_sel_r == 1'(bk))) acc_r[bk][b] <= '0;
          else if (s2_v_r && (s2_bank_r == 1'(bk))) begin
            if (int'(s2_band_r) == b) acc_r[bk][b] <= acc_r[bk][b] + AW'(s2_plo_r);
            else if (int'(s2_band_r) + 1 == b) acc_r[bk][b] <= acc_r[bk][b] + AW'(s2_phi_r);
          end
        end
      end
    end
  end

  // Drain output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0; out_last_r <= 1'b0;
      out_data_r <= '0; out_band_r <= '0; out_ch_r <= '0;
    end else if (drain_start_s) begin
      out_valid_r <= 1'b1;
      out_band_r  <= '0;
      out_data_r  <= rd_val_s;
      out_ch_r    <= bank_ch_r[drain_sel_r];
      out_last_r  <= (MEL_BANDS == 1);
    end else if (drain_end_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (drain_fire_s) begin
      out_band_r <= rd_band_s;
      out_data_r <= rd_val_s;
      out_last_r <= (out_band_r == BAND_W'(MEL_BANDS - 2));
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_band  = out_band_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_last  = out_last_r;
  assign frame_err     = frame_err_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_mel_fbank_pp.sv
// Directed bench for mel_fbank_pp: linear/log output, triangle split, saturation,
// ping-pong under backpressure, short frames, reset mid-drain and config lockout.
module tb_mel_fbank_pp;
  localparam int NB = 257;
  localparam int MB = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [8:0]  cfg_addr = 9'd0;
  logic [5:0]  cfg_band = 6'd0;
  logic [11:0] cfg_wlo = 12'd0;
  logic [11:0] cfg_whi = 12'd0;
  logic        frame_err, busy;

  mel_fbank_pp_if #(.WIDTH(16), .MEL_BANDS(40), .N_CH(4)) bus ();

  mel_fbank_pp dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_band(cfg_band),
    .cfg_wlo(cfg_wlo), .cfg_whi(cfg_whi), .bus(bus), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  logic [15:0] g_data [80];
  logic [5:0]  g_band [80];
  logic [1:0]  g_ch [80];
  logic        g_last [80];
  logic        g_rdy_at [80];
  logic        g_rdy_nxt [80];
  int          g_n, g_first;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int a, input int b, input int wl, input int wh);
    cfg_we = 1'b1; cfg_addr = 9'(a); cfg_band = 6'(b); cfg_wlo = 12'(wl); cfg_whi = 12'(wh);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_frame(input int nbins, input logic [15:0] dflt, input int sp_idx,
                            input logic [15:0] sp_val, input logic [1:0] ch, input logic md);
    for (int i = 0; i < nbins; i++) begin
      logic rdy;
      int   w;
      bus.in_valid = 1'b1;
      bus.in_data  = (i == sp_idx) ? sp_val : dflt;
      bus.in_last  = (i == nbins - 1);
      bus.in_ch    = ch;
      bus.mode_log = md;
      w = 0;
      do begin
        rdy = bus.in_ready;
        @(posedge clk); #1;
        w++;
      end while (!rdy && w < 2000);
      if (!rdy) begin
        tests++; fails++;
        $display("FAIL send_timeout: bin %0d never accepted, in_ready=%b want 1", i, rdy);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic collect(input int nbeats, input int budget);
    int   k;
    logic pend;
    g_n = 0; g_first = -1; k = 0; pend = 1'b0;
    while (g_n < nbeats && k < budget) begin
      if (pend) begin g_rdy_nxt[g_n-1] = bus.in_ready; pend = 1'b0; end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (g_first < 0) g_first = k;
        g_data[g_n] = bus.out_data; g_band[g_n] = bus.out_band; g_ch[g_n] = bus.out_ch;
        g_last[g_n] = bus.out_last; g_rdy_at[g_n] = bus.in_ready;
        g_n++; pend = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (pend) g_rdy_nxt[g_n-1] = bus.in_ready;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 ||
        frame_err !== 1'b0 || bus.out_data !== 16'd0) begin
      fails++;
      $display("FAIL reset: out_valid=%b in_ready=%b busy=%b frame_err=%b out_data=%h, want 0 1 0 0 0000",
               bus.out_valid, bus.in_ready, busy, frame_err, bus.out_data);
    end
  endtask

  task automatic test_unity_linear();
    for (int i = 0; i < NB; i++) cfg_write(i, 0, 4095, 0);
    bus.out_ready = 1'b1;
    send_frame(NB, 16'd1, -1, 16'd0, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (g_n !== MB) begin fails++; $display("FAIL unity_count: got %0d beats want %0d", g_n, MB); end
    tests++;
    if (g_first + 1 !== 4) begin fails++; $display("FAIL unity_latency: got %0d cycles want 4", g_first + 1); end
    for (int i = 0; i < MB; i++) begin
      tests++;
      if (g_band[i] !== 6'(i) || g_data[i] !== ((i == 0) ? 16'd256 : 16'd0) ||
          g_last[i] !== (i == MB - 1) || g_ch[i] !== 2'd0) begin
        fails++;
        $display("FAIL unity_beat%0d: band %0d data %0d last %b ch %0d, want band %0d data %0d last %b ch 0",
                 i, g_band[i], g_data[i], g_last[i], g_ch[i], i, (i == 0) ? 256 : 0, i == MB - 1);
      end
    end
  endtask

  task automatic test_log();
    send_frame(NB, 16'd1, -1, 16'd0, 2'd3, 1'b1);
    collect(MB, 200);
    tests++;
    if (g_n !== MB) begin fails++; $display("FAIL log_count: got %0d beats want %0d", g_n, MB); end
    for (int i = 0; i < MB; i++) begin
      tests++;
      if (g_data[i] !== ((i == 0) ? 16'h5003 : 16'h0000) || g_ch[i] !== 2'd3) begin
        fails++;
        $display("FAIL log_beat%0d: data %h ch %0d, want data %h ch 3", i, g_data[i], g_ch[i],
                 (i == 0) ? 16'h5003 : 16'h0000);
      end
    end
  endtask

  task automatic test_saturation();
    send_frame(NB, 16'hFFFF, -1, 16'd0, 2'd1, 1'b0);
    collect(MB, 200);
    tests++;
    if (g_n !== MB || g_data[0] !== 16'hFFFF || g_data[1] !== 16'h0000) begin
      fails++;
      $display("FAIL saturation: beats %0d band0 %h band1 %h, want 40 FFFF 0000", g_n, g_data[0], g_data[1]);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    send_frame(NB, 16'd1, -1, 16'd0, 2'd1, 1'b0);
    send_frame(NB, 16'd2, -1, 16'd0, 2'd2, 1'b0);
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall: in_ready=%b want 0", bus.in_ready); end
    repeat (200) @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_band !== 6'd0 || bus.out_data !== 16'd256 ||
        bus.out_ch !== 2'd1 || bus.out_last !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_hold: valid %b band %0d data %0d ch %0d last %b busy %b, want 1 0 256 1 0 1",
               bus.out_valid, bus.out_band, bus.out_data, bus.out_ch, bus.out_last, busy);
    end
    bus.out_ready = 1'b1;
    collect(2 * MB, 400);
    tests++;
    if (g_n !== 2 * MB) begin fails++; $display("FAIL b2b_count: got %0d beats want 80", g_n); end
    for (int i = 0; i < 2 * MB; i++) begin
      int b;
      b = i % MB;
      tests++;
      if (g_band[i] !== 6'(b) || g_ch[i] !== ((i < MB) ? 2'd1 : 2'd2) ||
          g_data[i] !== ((b != 0) ? 16'd0 : (i < MB) ? 16'd256 : 16'd513)) begin
        fails++;
        $display("FAIL b2b_beat%0d: band %0d ch %0d data %0d, want band %0d ch %0d data %0d", i,
                 g_band[i], g_ch[i], g_data[i], b, (i < MB) ? 1 : 2, (b != 0) ? 0 : (i < MB) ? 256 : 513);
      end
    end
    tests++;
    if (g_rdy_at[MB-1] !== 1'b0 || g_rdy_nxt[MB-1] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_release: in_ready at A last %b after %b, want 0 then 1", g_rdy_at[MB-1], g_rdy_nxt[MB-1]);
    end
  endtask

  task automatic test_short_frame();
    int e0;
    e0 = err_cnt;
    send_frame(101, 16'd1, -1, 16'd0, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL short_err: got %0d pulses want 1", err_cnt - e0); end
    tests++;
    if (g_n !== MB || g_data[0] !== 16'd100 || g_last[MB-1] !== 1'b1) begin
      fails++;
      $display("FAIL short_out: beats %0d band0 %0d last %b, want 40 100 1", g_n, g_data[0], g_last[MB-1]);
    end
    e0 = err_cnt;
    send_frame(NB, 16'd1, -1, 16'd0, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (err_cnt - e0 !== 0 || g_n !== MB || g_data[0] !== 16'd256) begin
      fails++;
      $display("FAIL short_next: pulses %0d beats %0d band0 %0d, want 0 40 256", err_cnt - e0, g_n, g_data[0]);
    end
  endtask

  task automatic test_triangle();
    do_reset();
    cfg_write(5, 3, 1024, 3072);
    bus.out_ready = 1'b1;
    send_frame(NB, 16'd7, 5, 16'd4096, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (g_n !== MB) begin fails++; $display("FAIL tri_count: got %0d beats want %0d", g_n, MB); end
    for (int i = 0; i < MB; i++) begin
      logic [15:0] exp;
      exp = (i == 3) ? 16'd1024 : (i == 4) ? 16'd3072 : 16'd0;
      tests++;
      if (g_data[i] !== exp) begin
        fails++; $display("FAIL tri_band%0d: got %0d want %0d", i, g_data[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int w;
    int seen;
    bus.out_ready = 1'b0;
    send_frame(NB, 16'd7, 5, 16'd4096, 2'd0, 1'b0);
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
    tests++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre: out_valid=%b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_async: out_valid=%b busy=%b want 0 0", bus.out_valid, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_partial: %0d valid cycles want 0", seen); end
    send_frame(NB, 16'd7, 5, 16'd4096, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (g_n !== MB || g_data[3] !== 16'd0 || g_data[4] !== 16'd0) begin
      fails++;
      $display("FAIL rst_table: beats %0d band3 %0d band4 %0d, want 40 0 0", g_n, g_data[3], g_data[4]);
    end
  endtask

  task automatic test_cfg_busy();
    fork
      send_frame(NB, 16'd100, -1, 16'd0, 2'd0, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL cfg_busy_flag: busy=%b want 1", busy); end
        cfg_write(10, 2, 4095, 0);
      end
    join
    collect(MB, 200);
    send_frame(NB, 16'd100, -1, 16'd0, 2'd0, 1'b0);
    collect(MB, 200);
    tests++;
    if (g_n !== MB || g_data[2] !== 16'd0) begin
      fails++; $display("FAIL cfg_ignored: beats %0d band2 %0d, want 40 0", g_n, g_data[2]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.in_last = 1'b0;
    bus.in_ch = 2'd0; bus.mode_log = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_unity_linear();
    test_log();
    test_saturation();
    test_back_to_back();
    test_short_frame();
    test_triangle();
    test_reset_mid_drain();
    test_cfg_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
